// File: rtl/demux_4_32_reg.sv
// -----------------------------------------------------------------------------
// demux_4_32_reg
//   Registered 1-to-4 demultiplexer with a per-channel valid/ready handshake.
//   A single producer stream is routed by `select` into one of four one-entry
//   holding registers. Each channel drains to its own consumer. A free-running
//   counter tracks how many input words have been accepted.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   data_in     word to route (WIDTH)
//   select      destination channel 0..3, sampled with data_in
//   in_valid    producer offers data_in/select
//   in_ready    word is accepted this cycle (combinational)
//   enable      gates acceptance of new words; draining is unaffected
//   data_0..3   per-channel holding-register contents (WIDTH)
//   out_valid   bit n: data_n holds an undelivered word
//   out_ready   bit n: consumer n takes data_n this cycle
//   accept_cnt  accepted-word count, wraps modulo 2^CNT_W
//
// Build option
//   DEMUX_TRISTATE_OUT_EN : when defined, data_n floats to all-Z while
//   out_valid[n]=0. Register contents, handshake and counter are unchanged.
// -----------------------------------------------------------------------------

// One channel: a single holding register plus its valid flag.
module demux_4_32_reg_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,   // accept a new word into this channel
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,  // consumer takes the held word
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain on the same edge: the consumer takes the old
  // word while the new one is written, so valid stays high (full rate).
  // Data is only written on load, so it holds steady while stalled and keeps
  // the last delivered word once the channel empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

module demux_4_32_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] accept_cnt
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            w_lane_vld;
  logic [NUM_LANES-1:0][WIDTH-1:0] w_lane_data;
  logic [NUM_LANES-1:0]            w_load;
  logic                            w_sel_free;
  logic                            w_accept;
  logic [CNT_W-1:0]                r_cnt;

  // Only the selected channel matters: it can take a word if empty, or if
  // its consumer is draining it on this same edge.
  assign w_sel_free = ~w_lane_vld[select] | out_ready[select];
  assign in_ready   = enable & w_sel_free;

  // in_valid gates everything, so an undriven select/data_in while idle
  // never reaches any register.
  assign w_accept   = in_valid & in_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_load[g] = w_accept & (select == 2'(g));

      demux_4_32_reg_lane #(.WIDTH(WIDTH)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load[g]),
        .i_data  (data_in),
        .i_ready (out_ready[g]),
        .o_valid (w_lane_vld[g]),
        .o_data  (w_lane_data[g])
      );
    end
  endgenerate

  // Accepted-word counter; natural wrap from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 1'b1;
  end

  assign accept_cnt = r_cnt;
  assign out_valid  = w_lane_vld;

`ifdef DEMUX_TRISTATE_OUT_EN
  // Empty channels release their bus; the stored word is kept internally.
  assign data_0 = w_lane_vld[0] ? w_lane_data[0] : {WIDTH{1'bz}};
  assign data_1 = w_lane_vld[1] ? w_lane_data[1] : {WIDTH{1'bz}};
  assign data_2 = w_lane_vld[2] ? w_lane_data[2] : {WIDTH{1'bz}};
  assign data_3 = w_lane_vld[3] ? w_lane_data[3] : {WIDTH{1'bz}};
`else
  assign data_0 = w_lane_data[0];
  assign data_1 = w_lane_data[1];
  assign data_2 = w_lane_data[2];
  assign data_3 = w_lane_data[3];
`endif

endmodule

// File: doc/demux_4_32_reg.md
Name: demux_4_32_reg

Overview:
- Registered 1-to-4 demultiplexer with per-output valid/ready handshake. It is the distribution counterpart of the 4:1 32-bit mux.
- Routes a 32-bit word from a single input stream to one of four output channels chosen by select. Each channel has a one-entry holding register.
- Sits between a single producer and four independent consumers.
- Counts completed input transfers for status and debug.

Parameters:
- WIDTH, 32, data width of the input and of each output channel.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to route.
- select  input  2  destination channel, 0..3; sampled together with data_in.
- in_valid  input  1  producer has a word on data_in/select.
- in_ready  output  1  block accepts the word this cycle.
- enable  input  1  gates acceptance of new input words.
- data_0, data_1, data_2, data_3  output  WIDTH  per-channel holding-register contents.
- out_valid  output  4  bit n set means data_n holds an undelivered word.
- out_ready  input  4  bit n set means consumer n takes data_n this cycle.
- accept_cnt  output  CNT_W  number of accepted input words, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=1 at a clk edge): out_valid=4'b0000, data_0..data_3=0, accept_cnt=0. Reset overrides every other event in the same cycle, including a word in flight or held; held words are discarded.
- in_ready is combinational: enable AND (NOT out_valid[select] OR out_ready[select]). It depends only on the selected channel.
- Accept condition: in_valid AND in_ready at a clk edge. On accept:
  - data_<select> <= data_in.
  - out_valid[select] <= 1.
  - accept_cnt <= accept_cnt + 1, wrapping from all-ones to 0.
- Delivery on channel n: out_valid[n] AND out_ready[n] at a clk edge. out_valid[n] <= 0 unless the same edge also accepts a new word into channel n.
- Simultaneous delivery and reload on the same channel: the new word is loaded and out_valid[n] stays 1, giving full throughput of one word per cycle per channel.
- Latency: a word accepted at edge k is visible on data_n with out_valid[n]=1 after edge k.
- A consumer can take the word at edge k+1 at the earliest.
- Channels are independent. A stalled channel (valid=1, ready=0) blocks only inputs that select it; inputs selecting other channels still flow.
- Only one channel can load per cycle, since there is a single input. Any number of channels can drain in the same cycle.
- enable=0:
  - in_ready=0 and no accepts occur.
  - Held words still drain normally.
  - accept_cnt holds its value.
- Held-data stability: while out_valid[n]=1 and out_ready[n]=0, data_n does not change.
- When out_valid[n]=0, data_n retains the last delivered word (no clearing), unless the optional feature is compiled in.
- select and data_in are ignored when in_valid=0. No X propagates into state.

Optional Feature:
- Macro: DEMUX_TRISTATE_OUT_EN.
- Defined: each data_n is driven to all-Z whenever out_valid[n]=0, matching the high-Z convention of the mux enable path. The internal register contents are unchanged.
- Not defined: data_n always drives the holding-register value.
- The handshake and the counter are identical in both builds.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset for 2 cycles, then in_valid=0.
  - Required: out_valid=0000, accept_cnt=0, in_ready=1 with enable=1.
  - With the macro defined: data_0..3 are all-Z.
- Single route:
  - Stimulus: data_in=32'hDEADBEEF, select=2, in_valid=1 for one cycle, out_ready=0000.
  - Required: the next cycle shows out_valid=0100, data_2=DEADBEEF, accept_cnt=1.
  - Then drive out_ready[2]=1 for one cycle; required: out_valid=0000.
- Backpressure isolation:
  - Stimulus: channel 1 holds a word with out_ready[1]=0; offer select=1, then select=3 with data 32'h12345678.
  - Required: in_ready=0 for select=1; in_ready=1 for select=3; data_3=12345678 is loaded; data_1 is unchanged.
- Full throughput:
  - Stimulus: out_ready[0]=1 continuously; stream 8 words 0..7 to select=0 on back-to-back cycles.
  - Required: in_ready=1 every cycle; data_0 takes values 0..7 in order; accept_cnt=8.
- Enable gating:
  - Stimulus: enable=0 with in_valid=1 for 5 cycles while channel 0 drains a held word.
  - Required: in_ready=0, accept_cnt unchanged, out_valid[0] clears after its handshake.
- Counter wrap and mid-operation reset:
  - Stimulus: preload accept_cnt to 16'hFFFF via 65535 accepts, then accept once; then pulse reset while out_valid=1111.
  - Required: after the extra accept, accept_cnt=0000; after the reset, out_valid=0000.
